// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: widths, round constants, packed state and the round functions.
package sha256_pkg;

  localparam int WORD_W   = 32;
  localparam int STATE_W  = 256;
  localparam int WINDOW_W = 288;

  typedef logic [WORD_W-1:0] word_t;

  // a occupies the most significant word, matching the wire format
  typedef struct packed {
    word_t a, b, c, d, e, f, g, h;
  } state_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam word_t K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t big_sigma0(input word_t x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round_core.sv
// Purely combinational SHA-256 compression round: state_i, W, K -> state_o.
module sha256_round_core
  import sha256_pkg::*;
(
  input  logic [STATE_W-1:0] state_i,
  input  logic [WORD_W-1:0]  w_i,
  input  logic [WORD_W-1:0]  k_i,
  output logic [STATE_W-1:0] state_o
);

  state_t s;
  state_t r;
  word_t  t1;
  word_t  t2;

  assign s = state_t'(state_i);

  always_comb begin
    t1  = s.h + big_sigma1(s.e) + ch(s.e, s.f, s.g) + k_i + w_i;
    t2  = big_sigma0(s.a) + maj(s.a, s.b, s.c);
    r.a = t1 + t2;
    r.b = s.a;
    r.c = s.b;
    r.d = s.c;
    r.e = s.d + t1;
    r.f = s.e;
    r.g = s.f;
    r.h = s.g;
  end

  assign state_o = r;

endmodule

// File: rtl/sha256_round_pipeline_stage.sv
// One SHA-256 round per item, 1-cycle latency; a one-entry skid keeps in_ready purely registered.
// Define SHA256_STAGE_TAG_EN to carry a 32-bit tag (tag_in/tag_out) alongside each item.
module sha256_round_pipeline_stage
  import sha256_pkg::*;
#(
  parameter logic [WORD_W-1:0] ROUND_K = K_TABLE[24]
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WINDOW_W-1:0] window_in,
  input  logic [STATE_W-1:0]  state_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [STATE_W-1:0]  window_out,
  output logic [STATE_W-1:0]  state_out
`ifdef SHA256_STAGE_TAG_EN
  ,
  input  logic [WORD_W-1:0]   tag_in,
  output logic [WORD_W-1:0]   tag_out
`endif
);

`ifdef SHA256_STAGE_TAG_EN
  localparam int ITEM_W = 2*STATE_W + WORD_W;
`else
  localparam int ITEM_W = 2*STATE_W;
`endif

  occ_e               occ_q;
  logic [ITEM_W-1:0]  main_q;
  logic [ITEM_W-1:0]  skid_q;
  logic [ITEM_W-1:0]  item_d;
  logic [STATE_W-1:0] round_st;
  logic               accept;
  logic               unused_oldest_word;

  sha256_round_core u_core (
    .state_i (state_in),
    .w_i     (window_in[WORD_W-1:0]),
    .k_i     (ROUND_K),
    .state_o (round_st)
  );

  // w1 is consumed by this round's expander partner upstream; it is simply dropped here
  assign unused_oldest_word = ^window_in[WINDOW_W-1:STATE_W];

`ifdef SHA256_STAGE_TAG_EN
  assign item_d = {tag_in, window_in[STATE_W-1:0], round_st};
  assign {tag_out, window_out, state_out} = main_q;
`else
  assign item_d = {window_in[STATE_W-1:0], round_st};
  assign {window_out, state_out} = main_q;
`endif

  assign in_ready  = ~RST & (occ_q != OCC_FULL);
  assign out_valid = (occ_q != OCC_EMPTY);
  assign accept    = in_valid & in_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      occ_q  <= OCC_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      unique case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            main_q <= item_d;
            occ_q  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && out_ready) begin
            main_q <= item_d;
          end else if (accept) begin
            skid_q <= item_d;
            occ_q  <= OCC_FULL;
          end else if (out_ready) begin
            occ_q  <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (out_ready) begin
            main_q <= skid_q;
            occ_q  <= OCC_ONE;
          end
        end
        default: occ_q <= OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: doc/sha256_round_pipeline_stage.md
# sha256_round_pipeline_stage

Compression-round stage that sits directly downstream of a message-expander pipeline stage. It consumes the expander's registered 288-bit window (eight message words plus the newly expanded word). It performs one SHA-256 compression round on the 256-bit working state, using the newest word and a per-instance round constant. It forwards the updated state and the 256-bit shifted window, oldest word dropped, to the next expander/round pair. A valid/ready handshake with a one-entry skid slot allows back-pressure across the chain without losing throughput.

## Interface
- ROUND_K, 32'h983e5152: round constant K[t] applied by this instance.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream presents window_in/state_in.
- in_ready  out  1  stage can accept this cycle.
- window_in  in  288  {w1..w8,w_i}, w1 at [287:256], w_i at [31:0].
- state_in  in  256  {a,b,c,d,e,f,g,h}, a at [255:224].
- out_valid  out  1  window_out/state_out valid.
- out_ready  in  1  downstream accepts this cycle.
- window_out  out  256  window_in[255:0] = {w2..w8,w_i}.
- state_out  out  256  post-round {a',b',c',d',e',f',g',h'}.
- tag_in / tag_out  in/out  32  nonce sideband; present only with SHA256_STAGE_TAG_EN.

## Operation
- Round, all 32-bit sums mod 2^32, W = window_in[31:0]:
  - T1 = h + Σ1(e) + Ch(e,f,g) + ROUND_K + W.
  - T2 = Σ0(a) + Maj(a,b,c).
  - Σ1 = ROTR6^ROTR11^ROTR25.
  - Σ0 = ROTR2^ROTR13^ROTR22.
  - Ch = (e&f)^(~e&g).
  - Maj = (a&b)^(a&c)^(b&c).
  - Output: a'=T1+T2, b'=a, c'=b, d'=c, e'=d+T1, f'=e, g'=f, h'=g.
- Round result is computed combinationally from inputs and captured only on accept (in_valid & in_ready).
- Storage: main register (drives outputs) plus one skid register, each holding {window_out, state_out, tag}.
- Occupancy state machine:
  - EMPTY: main empty, skid empty.
  - ONE: main full, skid empty.
  - FULL: main full, skid full.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept & ~out_ready → FULL, result goes to skid.
  - ONE + accept & out_ready → ONE, main reloaded with the new result.
  - ONE + ~accept & out_ready → EMPTY.
  - FULL + out_ready → ONE, skid moves to main.
  - No accept is possible in FULL.
- in_ready = ~RST & (state != FULL). It depends only on registers, never combinationally on out_ready.
- out_valid = (state != EMPTY).
- Outputs hold stable while out_valid & ~out_ready.
- Ordering is strictly FIFO. No item is ever dropped or duplicated.

## Timing
- Latency: an item accepted at edge n is visible on outputs after edge n, i.e. one cycle, when the stage was EMPTY or draining.
- Throughput: one item per cycle while out_ready stays high.
- Reset:
  - While RST is high at an edge: state → EMPTY.
  - out_valid = 0, in_ready = 0.
  - Data registers → 0; window_out, state_out and tag_out read 0.
- Reset mid-operation discards both stored items. in_ready returns to 1 in the first cycle RST is low.
- Simultaneous accept and drain in ONE keeps occupancy constant and loses no data.

## Configuration
- SHA256_STAGE_TAG_EN defined:
  - tag_in/tag_out exist.
  - A 32-bit tag is stored alongside each item in both main and skid registers.
  - The tag follows its item exactly, with the same latency and ordering.
  - Tag resets to 0.
- Undefined: no tag ports and no tag storage. All other behaviour is identical.

## Structure
- Shared package sha256_pkg:
  - 64-entry K constant table.
  - Word/state/window width constants (32/256/288).
  - Σ0, Σ1, σ0, σ1, Ch, Maj functions.
  - Packed state type.
- Sub-module sha256_round_core: purely combinational round (state_in, W, K → state_out). It is reusable by the other round stages.
- Handshake and skid logic stay in this module.

## Test plan
- All-zero state and window, ROUND_K=0x983e5152, out_ready=1:
  - state_out = {0x983e5152,0,0,0,0x983e5152,0,0,0} one cycle after accept.
  - window_out = 0.
- state_in = {6a09e667,bb67ae85,3c6ef372,a54ff53a,510e527f,9b05688c,1f83d9ab,5be0cd19}, W = 0x61626380, ROUND_K = 0x428a2f98:
  - state_out = {5d6aebcd,6a09e667,bb67ae85,3c6ef372,fa2a4622,510e527f,9b05688c,1f83d9ab}.
- Stream 3 items with out_ready held 0:
  - Items 1 and 2 accepted; in_ready drops to 0 after the second.
  - Raise out_ready: items emerge 1, 2, 3 in order with no gap.
- Random in_valid/out_ready over 1000 items against a reference model:
  - Zero loss/duplication.
  - Outputs stable whenever out_valid & ~out_ready.
- Assert RST while FULL:
  - Next cycle out_valid = 0 and outputs = 0.
  - in_ready = 1 one cycle after RST falls.
- With SHA256_STAGE_TAG_EN, tags 0x00000001..0x00000004 under back-pressure: tag_out matches its item in every accepted output cycle.
